// File: rtl/cheshire_eoc_monitor.sv
// -----------------------------------------------------------------------------
// cheshire_eoc_monitor
//
// Purpose:
//   Multi-channel end-of-computation monitor. Each channel (hart, cluster,
//   preload path) signals completion by writing a word whose LSB is 1; the
//   upper DataWidth-1 bits carry its exit code. The monitor waits for every
//   channel enabled at start, applies an optional cycle timeout, and presents
//   one aggregate pass/fail status plus the exit code of the first failing
//   channel. All status outputs come straight from flops.
//
// Ports:
//   clk_i         clock
//   rst_ni        asynchronous active-low reset
//   start_i       arm / re-arm pulse (ignored while running)
//   clear_i       return to IDLE and clear all state (beats start_i)
//   chan_en_i     channels required to finish, sampled at start
//   timeout_i     RUN cycle budget, 0 = no timeout, sampled at start
//   chan_valid_i  per-channel write strobe
//   chan_data_i   per-channel EOC word, channel k at [k*DataWidth +: DataWidth]
//   chan_done_o   channel has reported EOC in this run
//   busy_o        monitor is in RUN
//   done_o        every enabled channel reported
//   timeout_o     budget expired before completion
//   pass_o        done_o with all captured exit codes zero
//   exit_code_o   exit code of the first failing channel, else 0
//   fail_idx_o    index of the first failing channel
//   fail_o        some channel reported a nonzero exit code
// -----------------------------------------------------------------------------
module cheshire_eoc_monitor #(
  parameter int unsigned NumChannels  = 4,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned TimeoutWidth = 32,
  parameter int unsigned IdxWidth     = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             start_i,
  input  logic                             clear_i,
  input  logic [NumChannels-1:0]           chan_en_i,
  input  logic [TimeoutWidth-1:0]          timeout_i,
  input  logic [NumChannels-1:0]           chan_valid_i,
  input  logic [NumChannels*DataWidth-1:0] chan_data_i,
  output logic [NumChannels-1:0]           chan_done_o,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             timeout_o,
  output logic                             pass_o,
  output logic [DataWidth-2:0]             exit_code_o,
  output logic [IdxWidth-1:0]              fail_idx_o,
  output logic                             fail_o
);

  localparam int unsigned CodeWidth = DataWidth - 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    DONE    = 2'd2,
    TIMEOUT = 2'd3
  } state_e;

  // Architectural state
  state_e                  state_q, state_d;
  logic [NumChannels-1:0]  en_q, en_d;
  logic [TimeoutWidth-1:0] tmo_q, tmo_d;
  logic [TimeoutWidth-1:0] cnt_q, cnt_d;
  logic [CodeWidth-1:0]    code_q [NumChannels];
  logic [CodeWidth-1:0]    code_d [NumChannels];
  logic [NumChannels-1:0]  chan_done_q, chan_done_d;
  logic                    done_q, done_d;
  logic                    timeout_q, timeout_d;
  logic                    pass_q, pass_d;
  logic                    fail_q, fail_d;
  logic [IdxWidth-1:0]     fail_idx_q, fail_idx_d;
  logic [CodeWidth-1:0]    exit_code_q, exit_code_d;

  // Per-cycle decode of the incoming writes
  logic [CodeWidth-1:0]    code_in_s [NumChannels];
  logic [NumChannels-1:0]  cap_s;
  logic [NumChannels-1:0]  new_fail_s;
  logic [IdxWidth-1:0]     first_idx_s;
  logic [CodeWidth-1:0]    first_code_s;
  logic                    found_s;
  logic                    arm_s;
  logic                    tmo_hit_s;

  // Split the packed data bus into per-channel codes and capture qualifiers.
  always_comb begin
    cap_s      = '0;
    new_fail_s = '0;
    for (int k = 0; k < NumChannels; k++) begin
      code_in_s[k]  = chan_data_i[k*DataWidth+1 +: CodeWidth];
      // Only the first EOC (LSB set) of an enabled, not-yet-done channel counts.
      cap_s[k]      = chan_valid_i[k] & en_q[k] & ~chan_done_q[k] & chan_data_i[k*DataWidth];
      new_fail_s[k] = cap_s[k] & (|code_in_s[k]);
    end
  end

  // Lowest-index failing capture of this cycle breaks same-cycle ties.
  always_comb begin
    first_idx_s  = '0;
    first_code_s = '0;
    found_s      = 1'b0;
    for (int k = 0; k < NumChannels; k++) begin
      first_idx_s  = (new_fail_s[k] & ~found_s) ? IdxWidth'(k) : first_idx_s;
      first_code_s = (new_fail_s[k] & ~found_s) ? code_in_s[k] : first_code_s;
      found_s      = found_s | new_fail_s[k];
    end
  end

  // Start is honoured outside RUN; timeout fires on the last budgeted cycle.
  always_comb begin
    arm_s     = start_i & (state_q != RUN);
    tmo_hit_s = (tmo_q != '0) && (cnt_q == (tmo_q - TimeoutWidth'(1)));
  end

  // Next-state and next-output logic for the monitor FSM.
  always_comb begin
    state_d     = state_q;
    en_d        = en_q;
    tmo_d       = tmo_q;
    cnt_d       = cnt_q;
    code_d      = code_q;
    chan_done_d = chan_done_q;
    done_d      = done_q;
    timeout_d   = timeout_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    fail_idx_d  = fail_idx_q;
    exit_code_d = exit_code_q;

    if (clear_i) begin
      state_d     = IDLE;
      en_d        = '0;
      tmo_d       = '0;
      cnt_d       = '0;
      chan_done_d = '0;
      done_d      = 1'b0;
      timeout_d   = 1'b0;
      pass_d      = 1'b0;
      fail_d      = 1'b0;
      fail_idx_d  = '0;
      exit_code_d = '0;
      for (int k = 0; k < NumChannels; k++) begin
        code_d[k] = '0;
      end
    end else if (arm_s) begin
      en_d        = chan_en_i;
      tmo_d       = timeout_i;
      cnt_d       = '0;
      chan_done_d = '0;
      done_d      = 1'b0;
      timeout_d   = 1'b0;
      pass_d      = 1'b0;
      fail_d      = 1'b0;
      fail_idx_d  = '0;
      exit_code_d = '0;
      for (int k = 0; k < NumChannels; k++) begin
        code_d[k] = '0;
      end
      // Nothing to wait for: complete immediately with a clean pass.
      if (chan_en_i == '0) begin
        state_d = DONE;
        done_d  = 1'b1;
        pass_d  = 1'b1;
      end else begin
        state_d = RUN;
      end
    end else begin
      case (state_q)
        RUN: begin
          cnt_d       = (cnt_q == {TimeoutWidth{1'b1}}) ? cnt_q : (cnt_q + TimeoutWidth'(1));
          chan_done_d = chan_done_q | cap_s;
          for (int k = 0; k < NumChannels; k++) begin
            code_d[k] = cap_s[k] ? code_in_s[k] : code_q[k];
          end
          // The first failure in time is sticky for the rest of the run.
          if (!fail_q && (new_fail_s != '0)) begin
            fail_d      = 1'b1;
            fail_idx_d  = first_idx_s;
            exit_code_d = first_code_s;
          end else begin
            fail_d      = fail_q;
          end
          // Completion is checked before timeout so a last-cycle EOC still passes.
          if (&(chan_done_d | ~en_q)) begin
            state_d = DONE;
            done_d  = 1'b1;
            pass_d  = ~fail_d;
          end else if (tmo_hit_s) begin
            state_d   = TIMEOUT;
            timeout_d = 1'b1;
            pass_d    = 1'b0;
          end else begin
            state_d = RUN;
          end
        end
        IDLE, DONE, TIMEOUT: begin
          state_d = state_q;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and status registers with asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      en_q        <= '0;
      tmo_q       <= '0;
      cnt_q       <= '0;
      chan_done_q <= '0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_idx_q  <= '0;
      exit_code_q <= '0;
      for (int k = 0; k < NumChannels; k++) begin
        code_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      en_q        <= en_d;
      tmo_q       <= tmo_d;
      cnt_q       <= cnt_d;
      chan_done_q <= chan_done_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      fail_idx_q  <= fail_idx_d;
      exit_code_q <= exit_code_d;
      for (int k = 0; k < NumChannels; k++) begin
        code_q[k] <= code_d[k];
      end
    end
  end

  assign chan_done_o = chan_done_q;
  assign busy_o      = (state_q == RUN);
  assign done_o      = done_q;
  assign timeout_o   = timeout_q;
  assign pass_o      = pass_q;
  assign exit_code_o = exit_code_q;
  assign fail_idx_o  = fail_idx_q;
  assign fail_o      = fail_q;

endmodule

// File: doc/cheshire_eoc_monitor.md
Name: cheshire_eoc_monitor

Overview:
Synthesizable multi-channel end-of-computation (EOC) monitor for Cheshire simulation and FPGA bring-up. Each channel is a hart, cluster or preload path that reports completion by writing a word whose LSB is 1; the remaining bits are the exit code. The block collects EOCs from a configurable set of channels, applies a cycle timeout, and produces one aggregate pass/fail status and exit code. A bench or host polls this status instead of spinning on a single scratch register.

Parameters:
NumChannels, 4, number of EOC reporting channels (1..32)
DataWidth, 32, width of the EOC word; exit code is DataWidth-1 bits
TimeoutWidth, 32, width of the cycle timeout counter
IdxWidth, $clog2(NumChannels) (min 1), width of the channel index output

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
start_i  in  1  arm or re-arm the monitor (pulse)
clear_i  in  1  return to IDLE and clear all state (pulse)
chan_en_i  in  NumChannels  channels required to finish; sampled at start
timeout_i  in  TimeoutWidth  cycle budget in RUN; 0 disables the timeout; sampled at start
chan_valid_i  in  NumChannels  per-channel write strobe
chan_data_i  in  NumChannels*DataWidth  per-channel EOC word, channel k at [k*DataWidth +: DataWidth]
chan_done_o  out  NumChannels  channel has reported EOC this run
busy_o  out  1  FSM in RUN
done_o  out  1  all enabled channels reported
timeout_o  out  1  timeout expired before completion
pass_o  out  1  done_o and every captured exit code is 0
exit_code_o  out  DataWidth-1  aggregate exit code
fail_idx_o  out  IdxWidth  index of the first failing channel
fail_o  out  1  at least one channel reported a nonzero code

Behaviour:
- Reset: FSM enters IDLE. All outputs are 0. Per-channel code registers, the enable mask and the counter are cleared.
- FSM states: IDLE, RUN, DONE, TIMEOUT.
- IDLE to RUN: on start_i. Latch chan_en_i and timeout_i, clear all per-channel state, and set the counter to 0.
- Start with chan_en_i == 0: go straight to DONE on the next cycle with pass_o=1 and exit_code_o=0.
- EOC capture in RUN: channel k is captured when chan_valid_i[k] is high, the latched enable bit k is 1, chan_done_o[k] is 0, and data[0] is 1.
  - Captured code is data[DataWidth-1:1].
  - Writes with data[0]=0 (progress writes) are ignored.
  - Writes from disabled channels are ignored.
  - Repeat writes from a channel that is already done are ignored; the first EOC wins.
- Several channels in the same cycle: all are captured in that cycle.
- Failure tracking: fail_idx_o records the earliest-in-time capture with a nonzero code; ties within one cycle go to the lowest index. fail_o becomes 1 on that capture. Both stay fixed until the next start or clear.
- exit_code_o: the code of channel fail_idx_o while fail_o=1, otherwise 0. It is updated registered, on the cycle after capture.
- RUN to DONE: when every enabled channel is done, including captures made in the current cycle. done_o and pass_o are registered, so they assert on the cycle after the last capture.
- Timeout:
  - The counter increments every RUN cycle and saturates at all-ones.
  - If timeout_i is nonzero and the counter equals timeout_i - 1 while completion is still outstanding, the FSM goes to TIMEOUT. timeout_o=1, pass_o=0.
  - Completion and timeout in the same cycle: DONE wins.
- DONE and TIMEOUT hold all outputs until start_i (re-arm, equivalent to IDLE then RUN) or clear_i (go to IDLE).
- start_i while in RUN is ignored.
- clear_i has priority over start_i in every state. In RUN it aborts the run.
- Asynchronous reset in any state, including mid-run, immediately forces the reset values.
- busy_o = (state == RUN).

Test Plan:
- NumChannels=4, en=4'b1111, timeout=0. Channels 0..3 write 0x1 over successive cycles. Expect: done_o=1 and pass_o=1 one cycle after the channel-3 write, exit_code_o=0, fail_o=0.
- en=4'b0110. Ch1 writes 0x2 (progress), then 0x7. Ch2 writes 0x1. Ch0 writes 0x5. Expect: ch0 ignored, ch1 code=3, fail_idx_o=1, exit_code_o=3, done_o=1, pass_o=0.
- Ch2 (code 5, data 0xB) and ch3 (code 9, data 0x13) write in the same cycle. Expect: fail_idx_o=2, exit_code_o=5. A later ch2 write of 0x3 is ignored.
- timeout=10, en=4'b0011, only ch0 reports. Expect: timeout_o=1 after 10 RUN cycles, busy_o=0, done_o=0. With ch1 reporting in exactly the expiry cycle instead, expect done_o=1 and timeout_o=0.
- Start with en=0. Expect: DONE on the next cycle, pass_o=1. Then clear_i: all outputs return to 0.
- Assert rst_ni low mid-RUN with two channels done. Expect: all outputs 0 immediately. After reset and start, chan_done_o restarts from 0.
